// File: rtl/alu_control_sequencer.sv
// Hardwired T0..T6 control-step generator for Mini SRC R-format ALU instructions.
// Strobes are registered decodes of the next step, so each is valid for its whole step.
module alu_control_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Run,
  input  logic [31:0] IR,
  input  logic        MemReady,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        Zlowout,
  output logic        ZHighout,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  AluOp,
  output logic        Done,
  output logic        Fault
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  typedef struct packed {
    logic        pc_out;
    logic        mar_in;
    logic        inc_pc;
    logic        pc_in;
    logic        read;
    logic        mdr_in;
    logic        mdr_out;
    logic        ir_in;
    logic        y_in;
    logic        zlow_in;
    logic        zhigh_in;
    logic        zlow_out;
    logic        zhigh_out;
    logic        lo_in;
    logic        hi_in;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  alu_op;
    logic        done;
  } ctrl_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  ctrl_t      ctrl_reg, ctrl_next;
  logic       fault_reg, fault_next;
  logic [3:0] wait_reg, wait_next, wait_inc;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_muldiv, is_legal;
  logic       unused_ir_bits;

  assign op             = IR[31:27];
  assign ra             = IR[26:23];
  assign rb             = IR[22:19];
  assign rc             = IR[18:15];
  assign unused_ir_bits = ^IR[14:0];
  assign is_muldiv      = (op == 5'b01111) || (op == 5'b10000);
  assign is_legal       = ((op >= 5'b00011) && (op <= 5'b01011)) || is_muldiv;

  always_comb begin
    state_next = state_reg;
    fault_next = fault_reg;
    wait_next  = wait_reg;
    wait_inc   = wait_reg + 4'd1;
    case (state_reg)
      IDLE: if (Run && !fault_reg) state_next = T0;
      T0: begin
        state_next = T1;
        wait_next  = '0;
      end
      T1: begin
        if (MemReady) begin
          state_next = T2;
        end else begin
          wait_next = wait_inc;
          if (wait_inc == WAIT_LIMIT) begin
            state_next = IDLE;
            fault_next = 1'b1;
          end
        end
      end
      // IR is held stable from here on, so the opcode can be judged on the way into T3
      T2: begin
        if (is_legal) begin
          state_next = T3;
        end else begin
          state_next = IDLE;
          fault_next = 1'b1;
        end
      end
      T3: state_next = T4;
      T4: state_next = T5;
      T5: begin
        if (is_muldiv) state_next = T6;
        else           state_next = Run ? T0 : IDLE;
      end
      T6:      state_next = Run ? T0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ctrl_next = '0;
    case (state_next)
      T0: begin
        ctrl_next.pc_out  = 1'b1;
        ctrl_next.mar_in  = 1'b1;
        ctrl_next.inc_pc  = 1'b1;
        ctrl_next.zlow_in = 1'b1;
      end
      T1: begin
        ctrl_next.read   = 1'b1;
        ctrl_next.mdr_in = 1'b1;
        // PC update happens once; later wait cycles only keep the read going
        if (state_reg == T0) begin
          ctrl_next.zlow_out = 1'b1;
          ctrl_next.pc_in    = 1'b1;
        end
      end
      T2: begin
        ctrl_next.mdr_out = 1'b1;
        ctrl_next.ir_in   = 1'b1;
      end
      T3: begin
        ctrl_next.rout = 16'd1 << rb;
        ctrl_next.y_in = 1'b1;
      end
      T4: begin
        ctrl_next.rout     = 16'd1 << rc;
        ctrl_next.alu_op   = op;
        ctrl_next.zlow_in  = 1'b1;
        ctrl_next.zhigh_in = is_muldiv;
      end
      T5: begin
        ctrl_next.zlow_out = 1'b1;
        if (is_muldiv) begin
          ctrl_next.lo_in = 1'b1;
        end else begin
          ctrl_next.rin  = 16'd1 << ra;
          ctrl_next.done = 1'b1;
        end
      end
      T6: begin
        ctrl_next.zhigh_out = 1'b1;
        ctrl_next.hi_in     = 1'b1;
        ctrl_next.done      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_reg <= IDLE;
      ctrl_reg  <= '0;
      fault_reg <= 1'b0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_next;
      fault_reg <= fault_next;
      wait_reg  <= wait_next;
    end
  end

  assign PCout    = ctrl_reg.pc_out;
  assign MARin    = ctrl_reg.mar_in;
  assign IncPC    = ctrl_reg.inc_pc;
  assign PCin     = ctrl_reg.pc_in;
  assign Read     = ctrl_reg.read;
  assign MDRin    = ctrl_reg.mdr_in;
  assign MDRout   = ctrl_reg.mdr_out;
  assign IRin     = ctrl_reg.ir_in;
  assign Yin      = ctrl_reg.y_in;
  assign ZLowIn   = ctrl_reg.zlow_in;
  assign ZHighIn  = ctrl_reg.zhigh_in;
  assign Zlowout  = ctrl_reg.zlow_out;
  assign ZHighout = ctrl_reg.zhigh_out;
  assign LOin     = ctrl_reg.lo_in;
  assign HIin     = ctrl_reg.hi_in;
  assign Rout     = ctrl_reg.rout;
  assign Rin      = ctrl_reg.rin;
  assign AluOp    = ctrl_reg.alu_op;
  assign Done     = ctrl_reg.done;
  assign Fault    = fault_reg;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: directed scenarios plus random instruction streams
// checked cycle by cycle against a step-list model of each instruction.
module tb_alu_control_sequencer;

  localparam int MEM_TIMEOUT = 15;

  logic        Clock, Clear, Run, MemReady;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin, Done, Fault;
  logic [15:0] Rout, Rin;
  logic [4:0]  AluOp;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in, done, fault;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  alu_op;
  } obs_t;

  obs_t exp_q[$];
  bit   mem_q[$];

  alu_control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .MemReady(MemReady),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .Zlowout(Zlowout), .ZHighout(ZHighout), .LOin(LOin),
    .HIin(HIin), .Rout(Rout), .Rin(Rin), .AluOp(AluOp), .Done(Done), .Fault(Fault)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = '0;
    o.pc_out = PCout;   o.mar_in = MARin;     o.inc_pc = IncPC;  o.pc_in = PCin;
    o.read = Read;      o.mdr_in = MDRin;     o.mdr_out = MDRout; o.ir_in = IRin;
    o.y_in = Yin;       o.zlow_in = ZLowIn;   o.zhigh_in = ZHighIn;
    o.zlow_out = Zlowout; o.zhigh_out = ZHighout; o.lo_in = LOin; o.hi_in = HIin;
    o.done = Done;      o.fault = Fault;      o.rout = Rout;     o.rin = Rin;
    o.alu_op = AluOp;
    return o;
  endfunction

  // Builds the expected per-cycle outputs of one instruction starting at T0, and the
  // MemReady value to drive in each of those cycles. Returns 1 if it ends in Fault.
  function automatic bit model_push(input logic [31:0] ir, input int waits);
    obs_t s;
    logic [4:0] op;
    bit md, legal;
    op    = ir[31:27];
    md    = (op == 5'd15) || (op == 5'd16);
    legal = ((op >= 5'd3) && (op <= 5'd11)) || md;
    exp_q.delete();
    mem_q.delete();
    s = '0; s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.zlow_in = 1;
    exp_q.push_back(s); mem_q.push_back(bit'($urandom_range(0, 1)));
    for (int i = 0; i < MEM_TIMEOUT && i <= waits; i++) begin
      s = '0; s.read = 1; s.mdr_in = 1; s.pc_in = (i == 0); s.zlow_out = (i == 0);
      exp_q.push_back(s); mem_q.push_back(i == waits);
    end
    if (waits >= MEM_TIMEOUT) return 1'b1;
    s = '0; s.mdr_out = 1; s.ir_in = 1;
    exp_q.push_back(s); mem_q.push_back(bit'($urandom_range(0, 1)));
    if (!legal) return 1'b1;
    s = '0; s.rout = 16'd1 << ir[22:19]; s.y_in = 1;
    exp_q.push_back(s); mem_q.push_back(bit'($urandom_range(0, 1)));
    s = '0; s.rout = 16'd1 << ir[18:15]; s.alu_op = op; s.zlow_in = 1; s.zhigh_in = md;
    exp_q.push_back(s); mem_q.push_back(bit'($urandom_range(0, 1)));
    s = '0; s.zlow_out = 1;
    if (md) s.lo_in = 1;
    else begin s.rin = 16'd1 << ir[26:23]; s.done = 1; end
    exp_q.push_back(s); mem_q.push_back(bit'($urandom_range(0, 1)));
    if (md) begin
      s = '0; s.zhigh_out = 1; s.hi_in = 1; s.done = 1;
      exp_q.push_back(s); mem_q.push_back(bit'($urandom_range(0, 1)));
    end
    return 1'b0;
  endfunction

  task automatic test_reset();
    obs_t o;
    Clear = 0; Run = 0; MemReady = 0; IR = '0;
    repeat (2) tick();
    o = sample(); tests++;
    if (o !== '0) begin $display("FAIL reset_outputs got=%h want=0", o); fails++; end
    Clear = 1;
    repeat (2) tick();
    o = sample(); tests++;
    if (o !== '0) begin $display("FAIL reset_idle got=%h want=0", o); fails++; end
  endtask

  task automatic test_alu_op();
    obs_t o, e;
    IR = 32'h4A920000; Run = 1; MemReady = 1;
    tick(); Run = 0;
    o = sample(); e = '0; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zlow_in = 1; tests++;
    if (o !== e) begin $display("FAIL shl_t0 got=%h want=%h", o, e); fails++; end
    tick();
    o = sample(); e = '0; e.read = 1; e.mdr_in = 1; e.pc_in = 1; e.zlow_out = 1; tests++;
    if (o !== e) begin $display("FAIL shl_t1 got=%h want=%h", o, e); fails++; end
    tick();
    o = sample(); e = '0; e.mdr_out = 1; e.ir_in = 1; tests++;
    if (o !== e) begin $display("FAIL shl_t2 got=%h want=%h", o, e); fails++; end
    tick();
    o = sample(); e = '0; e.rout = 16'h0004; e.y_in = 1; tests++;
    if (o !== e) begin $display("FAIL shl_t3 got=%h want=%h", o, e); fails++; end
    tick();
    o = sample(); e = '0; e.rout = 16'h0010; e.alu_op = 5'b01001; e.zlow_in = 1; tests++;
    if (o !== e) begin $display("FAIL shl_t4 got=%h want=%h", o, e); fails++; end
    tick();
    o = sample(); e = '0; e.zlow_out = 1; e.rin = 16'h0020; e.done = 1; tests++;
    if (o !== e) begin $display("FAIL shl_t5 got=%h want=%h", o, e); fails++; end
    tick();
    o = sample(); tests++;
    if (o !== '0) begin $display("FAIL shl_idle got=%h want=0", o); fails++; end
    $display("[TB] shl R5,R2,R4 ir=%h", IR);
  endtask

  task automatic test_muldiv();
    IR = 32'h78900000; Run = 1; MemReady = 1;
    tick(); Run = 0;
    repeat (4) tick();
    tests++;
    if (!(ZHighIn && ZLowIn && AluOp == 5'b01111)) begin
      $display("FAIL mul_t4 got zhi=%b zlo=%b op=%b want 1 1 01111", ZHighIn, ZLowIn, AluOp); fails++;
    end
    tick(); tests++;
    if (!(LOin && Zlowout && Rin == 16'h0 && !Done && !HIin)) begin
      $display("FAIL mul_t5 got lo=%b zlo=%b rin=%h done=%b want 1 1 0000 0", LOin, Zlowout, Rin, Done); fails++;
    end
    tick(); tests++;
    if (!(ZHighout && HIin && Done && !Zlowout && !LOin)) begin
      $display("FAIL mul_t6 got zho=%b hi=%b done=%b zlo=%b want 1 1 1 0", ZHighout, HIin, Done, Zlowout); fails++;
    end
    tick(); tests++;
    if (sample() !== '0) begin $display("FAIL mul_idle got=%h want=0", sample()); fails++; end
    $display("[TB] mul ir=%h", IR);
  endtask

  task automatic test_mem_wait();
    IR = {5'd3, 4'd7, 4'd8, 4'd9, 15'd0}; Run = 1; MemReady = 0;
    tick(); Run = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      MemReady = (i == 3);
      tests++;
      if (!(Read && MDRin && PCin == (i == 0) && Zlowout == (i == 0) && !IRin)) begin
        $display("FAIL wait_t1_%0d got rd=%b mdr=%b pcin=%b want 1 1 %b", i, Read, MDRin, PCin, i == 0); fails++;
      end
    end
    tick(); MemReady = 0; tests++;
    if (!(IRin && MDRout && !Read)) begin
      $display("FAIL wait_t2 got irin=%b rd=%b want 1 0", IRin, Read); fails++;
    end
    repeat (3) tick();
    tests++;
    if (!(Done && Rin == 16'h0080)) begin
      $display("FAIL wait_done got done=%b rin=%h want 1 0080", Done, Rin); fails++;
    end
    tick();
    $display("[TB] add with 3 wait cycles ir=%h", IR);
  endtask

  task automatic test_timeout();
    obs_t e;
    IR = {5'd4, 4'd1, 4'd2, 4'd3, 15'd0}; Run = 1; MemReady = 0;
    tick();
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      tick(); tests++;
      if (!(Read && !Fault)) begin
        $display("FAIL timeout_wait_%0d got rd=%b fault=%b want 1 0", i, Read, Fault); fails++;
      end
    end
    e = '0; e.fault = 1;
    tick(); tests++;
    if (sample() !== e) begin $display("FAIL timeout_fault got=%h want=%h", sample(), e); fails++; end
    repeat (4) tick();
    tests++;
    if (sample() !== e) begin $display("FAIL timeout_hold got=%h want=%h", sample(), e); fails++; end
    Run = 0; Clear = 0; #1; tests++;
    if (sample() !== '0) begin $display("FAIL timeout_clear got=%h want=0", sample()); fails++; end
    Clear = 1;
    tick(); tests++;
    if (sample() !== '0) begin $display("FAIL timeout_after got=%h want=0", sample()); fails++; end
    $display("[TB] memory timeout ir=%h", IR);
  endtask

  task automatic test_illegal_op();
    obs_t e;
    IR = {5'b11111, 27'($urandom)}; Run = 1; MemReady = 1;
    repeat (3) tick();
    tests++;
    if (!IRin) begin $display("FAIL illegal_t2 got irin=%b want 1", IRin); fails++; end
    e = '0; e.fault = 1;
    tick(); tests++;
    if (sample() !== e) begin $display("FAIL illegal_t3 got=%h want=%h", sample(), e); fails++; end
    repeat (2) tick();
    tests++;
    if (sample() !== e) begin $display("FAIL illegal_hold got=%h want=%h", sample(), e); fails++; end
    Run = 0; Clear = 0; #2; Clear = 1;
    tick();
    $display("[TB] illegal opcode ir=%h", IR);
  endtask

  task automatic test_back_to_back();
    IR = {5'd3, 4'd1, 4'd2, 4'd3, 15'd0}; Run = 1; MemReady = 1;
    repeat (6) tick();
    tests++;
    if (!(Done && Rin == 16'h0002)) begin
      $display("FAIL b2b_done1 got done=%b rin=%h want 1 0002", Done, Rin); fails++;
    end
    tick(); tests++;
    if (!(PCout && MARin && !Done)) begin
      $display("FAIL b2b_t0 got pcout=%b done=%b want 1 0", PCout, Done); fails++;
    end
    IR = {5'd3, 4'd10, 4'd11, 4'd12, 15'd0}; Run = 0;
    repeat (3) tick();
    tests++;
    if (!(Yin && Rout == 16'h0800)) begin
      $display("FAIL b2b_t3 got yin=%b rout=%h want 1 0800", Yin, Rout); fails++;
    end
    repeat (2) tick();
    tests++;
    if (!(Done && Rin == 16'h0400)) begin
      $display("FAIL b2b_done2 got done=%b rin=%h want 1 0400", Done, Rin); fails++;
    end
    tick(); tests++;
    if (sample() !== '0) begin $display("FAIL b2b_idle got=%h want=0", sample()); fails++; end
    $display("[TB] back-to-back add pair");
  endtask

  task automatic test_abort_reset();
    IR = 32'h4A920000; Run = 1; MemReady = 1;
    tick(); Run = 0;
    repeat (4) tick();
    tests++;
    if (AluOp !== 5'b01001) begin $display("FAIL abort_t4 got op=%b want 01001", AluOp); fails++; end
    Clear = 0; #1; tests++;
    if (sample() !== '0) begin $display("FAIL abort_async got=%h want=0", sample()); fails++; end
    tick(); tests++;
    if (sample() !== '0) begin $display("FAIL abort_next got=%h want=0", sample()); fails++; end
    Clear = 1;
    repeat (3) tick();
    tests++;
    if (sample() !== '0) begin $display("FAIL abort_idle got=%h want=0", sample()); fails++; end
    $display("[TB] reset during T4");
  endtask

  task automatic test_random();
    logic [4:0] legal_ops [11] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16};
    logic [4:0]  op;
    logic [31:0] ir;
    int   waits;
    bit   cont, next_run, faulted;
    obs_t o, e;
    cont = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0)
        op = 5'(($urandom_range(0, 1) != 0) ? $urandom_range(17, 31) : $urandom_range(0, 2));
      else
        op = legal_ops[$urandom_range(0, 10)];
      ir       = {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
      waits    = ($urandom_range(0, 11) == 0) ? MEM_TIMEOUT : int'($urandom_range(0, 4));
      next_run = (n == 39) ? 1'b0 : bit'($urandom_range(0, 1));
      faulted  = model_push(ir, waits);
      if (!cont) Run = 1;
      for (int k = 0; k < exp_q.size(); k++) begin
        tick();
        o = sample(); tests++;
        if (o !== exp_q[k]) begin
          $display("FAIL rand_step instr=%0d step=%0d got=%h want=%h", n, k, o, exp_q[k]); fails++;
        end
        MemReady = mem_q[k];
        if (k == 0) IR = ir;
        if (k == exp_q.size() - 1) Run = faulted ? 1'b1 : next_run;
      end
      if (faulted) begin
        e = '0; e.fault = 1;
        tick(); tests++;
        if (sample() !== e) begin $display("FAIL rand_fault instr=%0d got=%h want=%h", n, sample(), e); fails++; end
        Run = 0; Clear = 0; #2; Clear = 1;
        cont = 0;
      end else if (!next_run) begin
        tick(); tests++;
        if (sample() !== '0) begin $display("FAIL rand_idle instr=%0d got=%h want=0", n, sample()); fails++; end
        cont = 0;
      end else begin
        cont = 1;
      end
      $display("[TB] rand instr %0d ir=%h waits=%0d fault=%0b run_next=%0b", n, ir, waits, faulted, next_run);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_muldiv();
    test_mem_wait();
    test_timeout();
    test_illegal_op();
    test_back_to_back();
    test_abort_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
